multi_ch_synch_filter: RTL and testbench
========================================

# multi_ch_synch_filter

Parametrised multi-channel synchronizer for asynchronous single-bit inputs such as LVDS lock flags, link status and board straps. Each channel passes through a STAGES-deep flip-flop chain and then a per-channel stability filter, so only levels that hold for FILTER_CYCLES consecutive cycles reach the output. Registered rise/fall strobes go to downstream control FSMs. It replaces single-channel two-flop synchronizers wherever several related status bits enter the same clock domain.

## Interface

- STAGES, 2: synchronizer chain depth per channel; legal values >= 2.
- CHANNELS, 4: number of independent input bits; legal values >= 1.
- FILTER_CYCLES, 4: consecutive stable synchronized cycles required before the output changes; legal values >= 1 (1 = no filtering).
- RESET_VALUE, {CHANNELS{1'b0}}: per-channel reset level of the chain and output, CHANNELS bits wide.

- sync_clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- needs_to_be_synced  input  CHANNELS  asynchronous inputs; bit i = channel i.
- sync_out  output  CHANNELS  filtered, synchronized levels.
- rise_pulse  output  CHANNELS  one-cycle strobe when the sync_out bit goes 0->1.
- fall_pulse  output  CHANNELS  one-cycle strobe when the sync_out bit goes 1->0.
- any_change  output  1  OR-reduction of rise_pulse | fall_pulse, registered.

## Operation

- Per channel i, a shift chain of STAGES flops: chain[0] samples needs_to_be_synced[i], and each stage shifts forward every cycle. raw_i = chain[STAGES-1].
- Per channel filter counter cnt_i, width $clog2(FILTER_CYCLES) (min 1 bit). On each edge, when raw_i == sync_out[i]: cnt_i <= 0 and there are no pulses.
- When raw_i != sync_out[i] and cnt_i == FILTER_CYCLES-1:
  - sync_out[i] <= raw_i and cnt_i <= 0.
  - rise_pulse[i] <= raw_i and fall_pulse[i] <= !raw_i.
- When raw_i != sync_out[i] and cnt_i < FILTER_CYCLES-1: cnt_i <= cnt_i + 1 and there are no pulses.
- A glitch shorter than FILTER_CYCLES cycles at raw_i is discarded. The counter restarts from 0 on the first cycle raw_i matches sync_out again, so there is no partial credit.
- Pulses are high for exactly one cycle. An output can change at most once per FILTER_CYCLES cycles, so pulses on the same channel are never back to back when FILTER_CYCLES > 1.
- Channels are fully independent and may change in the same cycle. any_change is high in the same cycle as any pulse bit.
- Reset has priority over all other behaviour:
  - chain bits and sync_out[i] load RESET_VALUE[i];
  - cnt_i loads 0;
  - rise_pulse, fall_pulse and any_change load 0.
- Because the chain and output share the reset level, no pulse follows reset release unless the input differs from RESET_VALUE.

## Timing

- Reset values: sync_out = RESET_VALUE, rise_pulse = 0, fall_pulse = 0, any_change = 0.
- Latency: when needs_to_be_synced[i] changes before edge 1 and holds, raw_i changes after edge STAGES and sync_out[i] plus its pulse change after edge STAGES+FILTER_CYCLES. With defaults, that is after edge 6.
- A reset asserted mid-filter discards any pending count. After reset deasserts, a changed input needs the full STAGES+FILTER_CYCLES again.
- A raw toggle in the same cycle the count completes is not possible, because the count compares the registered raw value. The output takes the raw value present at the completing edge.
- No combinational path from input to output. Every output is a flop.

## Test plan

- Defaults: bit 0 goes 0->1 and holds. Expected: sync_out[0] = 1 and rise_pulse[0] = 1 after edge 6, rise_pulse[0] = 0 after edge 7, other bits stay quiet.
- Glitch: bit 1 is high for 3 cycles, then low. Expected: sync_out[1] stays 0 with no pulses. A 4-cycle high produces exactly one rise and then one fall, 4 cycles apart.
- Simultaneous: all 4 inputs toggle 0->1 on the same edge. Expected: rise_pulse = 4'hF in one cycle, any_change = 1 for that single cycle.
- Reset mid-filter: bit 2 goes high and reset asserts after edge 4 for 1 cycle. Expected: outputs are 0 and pulses are 0 after the reset edge, and sync_out[2] rises 6 edges after reset deasserts.
- Configuration STAGES=3, FILTER_CYCLES=1, RESET_VALUE=4'b1010 with inputs held at 4'b1010 through reset. Expected: no pulses after release. Bit 0 rising gives sync_out[0] = 1 after edge 4 with latency 4.
- Chatter: bit 3 alternates every cycle for 20 cycles. Expected: sync_out[3] never changes and there are no pulses.

Source files
------------

// File: rtl/multi_ch_synch_filter.sv
// Multi-channel single-bit synchronizer with per-channel stability filter.
// Each channel: STAGES-deep flop chain, then a hold-off counter gating output changes.
module multi_ch_synch_filter #(
  parameter int                  STAGES        = 2,
  parameter int                  CHANNELS      = 4,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
  input  logic                sync_clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] needs_to_be_synced,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CHANNELS-1:0] sync_out_reg;
  logic [CHANNELS-1:0] rise_reg;
  logic [CHANNELS-1:0] fall_reg;
  logic                any_reg;
  logic [CHANNELS-1:0] raw_vec;
  logic [CHANNELS-1:0] change_next;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [STAGES-1:0] chain_reg;
      logic [CNT_W-1:0]  cnt_reg;

      always_ff @(posedge sync_clock) begin
        if (reset) begin
          chain_reg <= {STAGES{RESET_VALUE[gi]}};
        end else begin
          chain_reg <= {chain_reg[STAGES-2:0], needs_to_be_synced[gi]};
        end
      end

      assign raw_vec[gi] = chain_reg[STAGES-1];

      // Output may only follow raw once the mismatch has persisted FILTER_CYCLES edges.
      assign change_next[gi] = (raw_vec[gi] != sync_out_reg[gi]) && (cnt_reg == CNT_LAST);

      always_ff @(posedge sync_clock) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (raw_vec[gi] == sync_out_reg[gi]) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge sync_clock) begin
    if (reset) begin
      sync_out_reg <= RESET_VALUE;
      rise_reg     <= '0;
      fall_reg     <= '0;
      any_reg      <= 1'b0;
    end else begin
      sync_out_reg <= (sync_out_reg & ~change_next) | (raw_vec & change_next);
      rise_reg     <= change_next & raw_vec;
      fall_reg     <= change_next & ~raw_vec;
      any_reg      <= |change_next;
    end
  end

  assign sync_out   = sync_out_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
  assign any_change = any_reg;

endmodule

// File: tb/tb_multi_ch_synch_filter.sv
// Directed bench: default instance (A) and STAGES=3/FILTER_CYCLES=1/RESET_VALUE=1010 instance (B).
module tb_multi_ch_synch_filter;

  logic       sync_clock;
  logic       reset;
  logic [3:0] din_a, din_b;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;
  logic       any_a, any_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] din;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [8];

  multi_ch_synch_filter dut_a (
    .sync_clock         (sync_clock),
    .reset              (reset),
    .needs_to_be_synced (din_a),
    .sync_out           (out_a),
    .rise_pulse         (rise_a),
    .fall_pulse         (fall_a),
    .any_change         (any_a)
  );

  multi_ch_synch_filter #(
    .STAGES        (3),
    .CHANNELS      (4),
    .FILTER_CYCLES (1),
    .RESET_VALUE   (4'b1010)
  ) dut_b (
    .sync_clock         (sync_clock),
    .reset              (reset),
    .needs_to_be_synced (din_b),
    .sync_out           (out_b),
    .rise_pulse         (rise_b),
    .fall_pulse         (fall_b),
    .any_change         (any_b)
  );

  initial sync_clock = 1'b0;
  always #5 sync_clock = ~sync_clock;

  task automatic tick();
    @(posedge sync_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] e_out,
                         input logic [3:0] e_rise, input logic [3:0] e_fall);
    $display("%s A din=%h out=%h rise=%h fall=%h any=%b", tag, din_a, out_a, rise_a, fall_a, any_a);
    chk({tag, "_a_out"},  out_a,  e_out);
    chk({tag, "_a_rise"}, rise_a, e_rise);
    chk({tag, "_a_fall"}, fall_a, e_fall);
    chk({tag, "_a_any"},  {3'b0, any_a}, {3'b0, |(e_rise | e_fall)});
  endtask

  task automatic check_b(input string tag, input logic [3:0] e_out,
                         input logic [3:0] e_rise, input logic [3:0] e_fall);
    $display("%s B din=%h out=%h rise=%h fall=%h any=%b", tag, din_b, out_b, rise_b, fall_b, any_b);
    chk({tag, "_b_out"},  out_b,  e_out);
    chk({tag, "_b_rise"}, rise_b, e_rise);
    chk({tag, "_b_fall"}, fall_b, e_fall);
    chk({tag, "_b_any"},  {3'b0, any_b}, {3'b0, |(e_rise | e_fall)});
  endtask

  initial begin
    // Bit 0 rises and holds: output and strobe after edge 6, strobe gone after edge 7.
    for (int i = 0; i < 8; i++) begin
      tbl[i].din  = 4'h1;
      tbl[i].out  = (i >= 5) ? 4'h1 : 4'h0;
      tbl[i].rise = (i == 5) ? 4'h1 : 4'h0;
      tbl[i].fall = 4'h0;
    end

    reset = 1'b1;
    din_a = 4'h0;
    din_b = 4'b1010;
    tick();
    tick();
    check_a("reset", 4'h0, 4'h0, 4'h0);
    check_b("reset", 4'b1010, 4'h0, 4'h0);

    // Release with inputs at the reset level: no strobes on either instance.
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_a("release", 4'h0, 4'h0, 4'h0);
      check_b("release", 4'b1010, 4'h0, 4'h0);
    end

    for (int i = 0; i < 8; i++) begin
      din_a = tbl[i].din;
      tick();
      check_a("table", tbl[i].out, tbl[i].rise, tbl[i].fall);
    end

    // 3-cycle glitch on bit 1 is discarded.
    din_a = 4'h3;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) din_a = 4'h1;
      tick();
      check_a("glitch3", 4'h1, 4'h0, 4'h0);
    end

    // 4-cycle pulse on bit 1: rise after edge 6, fall after edge 10.
    din_a = 4'h3;
    for (int e = 1; e <= 12; e++) begin
      if (e == 5) din_a = 4'h1;
      tick();
      check_a("pulse4", (e >= 6 && e < 10) ? 4'h3 : 4'h1,
              (e == 6) ? 4'h2 : 4'h0, (e == 10) ? 4'h2 : 4'h0);
    end

    // Return bit 0 low, then all four rise together.
    din_a = 4'h0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_a("drop0", (e >= 6) ? 4'h0 : 4'h1, 4'h0, (e == 6) ? 4'h1 : 4'h0);
    end
    din_a = 4'hF;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_a("simul", (e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0);
    end

    // Clear A back to zero through reset.
    din_a = 4'h0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_a("clr", 4'h0, 4'h0, 4'h0);

    // Reset mid-filter on bit 2 discards the pending count.
    din_a = 4'h4;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check_a("midf_pre", 4'h0, 4'h0, 4'h0);
    end
    reset = 1'b1;
    tick();
    check_a("midf_rst", 4'h0, 4'h0, 4'h0);
    check_b("midf_rst", 4'b1010, 4'h0, 4'h0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_a("midf_post", (e >= 6) ? 4'h4 : 4'h0, (e == 6) ? 4'h4 : 4'h0, 4'h0);
    end

    // Instance B: bit 0 rises, latency 4 with no filtering.
    din_b = 4'b1011;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_b("cfgb", (e >= 4) ? 4'b1011 : 4'b1010, (e == 4) ? 4'h1 : 4'h0, 4'h0);
    end

    // Chatter on bit 3 every cycle never reaches the output.
    for (int e = 1; e <= 20; e++) begin
      din_a[3] = ~din_a[3];
      tick();
      check_a("chatter", 4'h4, 4'h0, 4'h0);
    end
    din_a[3] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_a("chatter_tail", 4'h4, 4'h0, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
